// File: rtl/vx_elastic_pipe_if.sv
// Valid/ready handshake bundle carrying one DATAW-bit payload.
// The master drives valid/data; the slave drives ready.
interface vx_elastic_pipe_if #(
   parameter int unsigned DATAW = 1
);
   logic             valid;
   logic             ready;
   logic [DATAW-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vx_elastic_pipe.sv
// Elastic valid/ready pipeline of DEPTH independently loading stages with bubble collapsing.
// A synchronous flush kills all in-flight entries.
module vx_elastic_pipe #(
   parameter int unsigned DATAW = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   vx_elastic_pipe_if.slave               enq,
   vx_elastic_pipe_if.master              deq,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] valid_q;
   logic [DATAW-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] en;
   logic             chain;

   // A stage may load when it is empty or the stage ahead of it is also loading;
   // the chain is deliberately combinational from deq.ready back to enq.ready.
   always_comb begin
      chain = !valid_q[DEPTH-1] || deq.ready;
      en    = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         chain              = chain || !valid_q[DEPTH-1-k];
         en[DEPTH-1-k]      = chain;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         if (en[0]) valid_q[0] <= enq.valid;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if (en[i]) valid_q[i] <= valid_q[i-1];
         end
      end
   end

   // Payload registers are not reset; contents behind a cleared valid bit are don't-care.
   always_ff @(posedge clk) begin
      if (en[0]) data_q[0] <= enq.data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         if (en[i]) data_q[i] <= data_q[i-1];
      end
   end

   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         count = count + CW'(valid_q[i]);
      end
   end

   assign enq.ready = en[0] && !flush;
   assign deq.valid = valid_q[DEPTH-1];
   assign deq.data  = data_q[DEPTH-1];
endmodule

// File: doc/vx_elastic_pipe.md
# vx_elastic_pipe

Valid/ready elastic pipeline of DEPTH data stages with per-stage valid bits and bubble collapsing. It drops in wherever a fixed-latency enable-driven pipe register needs a backpressure-aware wrapper: each stage loads independently, so bubbles are squeezed out while the output is stalled. It sits between a producer with a valid/ready interface and a consumer that may deassert ready. It also provides a synchronous flush, used for pipeline kill on warp/branch redirect.

## Interface
- DATAW, 1, payload width in bits (>=1)
- DEPTH, 2, number of register stages (>=1); stage 0 is the input side, stage DEPTH-1 drives the output
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous kill of all stage contents
- valid_in  input  1  producer has data
- data_in  input  DATAW  producer payload
- ready_in  output  1  pipe accepts data_in this cycle
- valid_out  output  1  stage DEPTH-1 holds valid data
- data_out  output  DATAW  payload of stage DEPTH-1
- ready_out  input  1  consumer accepts data_out this cycle
- count  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- State per stage i:
  - valid_q[i]: reset to 0.
  - data_q[i]: DATAW bits, not reset; contents are don't-care while valid_q[i]=0.
- Stage load enable:
  - en[DEPTH-1] = !valid_q[DEPTH-1] || ready_out
  - en[i] = !valid_q[i] || en[i+1] for i < DEPTH-1
- On en[i] (not reset, not flush):
  - valid_q[i] <= (i==0 ? valid_in : valid_q[i-1])
  - data_q[i] <= (i==0 ? data_in : data_q[i-1])
- Data registers load only when en[i]=1. They are allowed to capture garbage when the source is invalid.
- ready_in = en[0] && !flush.
- Transfers: input transfer = valid_in && ready_in; output transfer = valid_out && ready_out.
- valid_out = valid_q[DEPTH-1]; data_out = data_q[DEPTH-1].
- count = popcount(valid_q). It equals accepted transfers minus delivered transfers since the last reset/flush and never exceeds DEPTH.
- Flush:
  - All valid_q cleared to 0 at the next edge; count becomes 0.
  - ready_in=0 during the flush cycle, so no input is accepted that cycle.
  - An output transfer coinciding with flush still counts as delivered.
- Reset has priority over flush. Flush has priority over normal advance.
- Ordering: data leaves in exactly the order accepted. No duplication, no loss except by flush/reset.
- Path note: the ready chain is combinational from ready_out to ready_in through all stages; this is intended.

## Timing
- Reset: valid_out=0, count=0. ready_in=1 from the first cycle after reset deasserts; ready_in is also 1 during reset whenever flush=0, but inputs are ignored while reset=1.
- Latency: data accepted at edge N appears on data_out with valid_out=1 after edge N+DEPTH-1, i.e. DEPTH edges including the accepting edge. This holds when the path is empty and there is no stall.
- Throughput: 1 transfer per cycle sustained while ready_out=1.
- Stall: while valid_out=1 and ready_out=0, data_out and valid_out are held stable. Upstream stages keep advancing into empty stages.
- Full: all valid_q=1 and ready_out=0 -> ready_in=0, count=DEPTH.
- Full and ready_out=1: ready_in=1 in the same cycle (pass-through of ready). Count is unchanged if valid_in=1.
- Empty: valid_out=0, count=0, ready_in=1. ready_out is ignored.
- DEPTH=1: single stage; ready_in = (!valid_q[0] || ready_out) && !flush.
- Reset mid-stream: all in-flight data discarded at that edge. No valid_out pulse afterwards until new data is accepted.

## Test plan
- Streaming, DEPTH=3, ready_out=1: valid_in=1 with data 1,2,3,… on consecutive cycles -> data_out shows 1 three edges after its accept, then one value per cycle. count stays 3 once filled.
- Bubble collapse, DEPTH=3: accept A, then an idle cycle, then accept B, with ready_out=0 throughout -> after 4 cycles data_out=A; A and B are adjacent, count=2, ready_in=1.
- Full backpressure, DEPTH=2: fill with X,Y, hold ready_out=0 -> ready_in=0, count=2, data_out=X stable for 10 cycles. Raise ready_out with valid_in=1 (Z) -> X out, ready_in=1 that cycle, count stays 2, then Y, then Z.
- Flush: count=2 with valid_in=1 and flush=1 -> ready_in=0 that cycle; next cycle valid_out=0, count=0; the input offered during flush is never output.
- Reset mid-operation: count=3 with valid_out=1, assert reset one cycle -> next cycle valid_out=0, count=0, ready_in=1; then accept 0x5A -> appears after DEPTH edges.
- Random scoreboard, DEPTH in {1,2,4}: random valid_in/ready_out/flush for 10k cycles -> in-order, no loss/duplication (except flushed entries), count matches the model every cycle.
